// File: rtl/operand_fetch_stage.sv
// Operand fetch stage: 8-entry register file with same-cycle write-back bypass,
// feeding a one-entry valid/ready output register toward execute.
module operand_fetch_stage #(
    parameter int DATA_WIDTH = 16,
    parameter int NUM_REGS   = 8,
    parameter int ADDR_WIDTH = 3
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [ADDR_WIDTH-1:0] in_rs1,
    input  logic [ADDR_WIDTH-1:0] in_rs2,
    input  logic [DATA_WIDTH-1:0] in_imm,
    input  logic [DATA_WIDTH-1:0] in_pc,
    input  logic                  wb_en,
    input  logic [ADDR_WIDTH-1:0] wb_addr,
    input  logic [DATA_WIDTH-1:0] wb_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_op1,
    output logic [DATA_WIDTH-1:0] out_op2,
    output logic [DATA_WIDTH-1:0] out_imm,
    output logic [DATA_WIDTH-1:0] out_pc
);

    // Handshake: a transfer happens on a rising edge where valid && ready are
    // both high; the producer holds its payload stable while valid && !ready.
    logic [DATA_WIDTH-1:0] regs [NUM_REGS];
    logic                  accept;
    logic [DATA_WIDTH-1:0] rd1;
    logic [DATA_WIDTH-1:0] rd2;

    assign in_ready = reset_n && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;

    always_comb begin
        rd1 = regs[in_rs1];
        rd2 = regs[in_rs2];
        if (wb_en && (wb_addr == in_rs1)) rd1 = wb_data;
        if (wb_en && (wb_addr == in_rs2)) rd2 = wb_data;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
            out_valid <= 1'b0;
            out_op1   <= '0;
            out_op2   <= '0;
            out_imm   <= '0;
            out_pc    <= '0;
        end else begin
            // Write-back proceeds even when the output register is stalled.
            if (wb_en) regs[wb_addr] <= wb_data;
            if (accept) begin
                out_valid <= 1'b1;
                out_op1   <= rd1;
                out_op2   <= rd2;
                out_imm   <= in_imm;
                out_pc    <= in_pc;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule
